// File: rtl/ama_riscv_wb_pair.sv
// Writeback sequencer: writes a plain result or a widened pair (rd, rd+1) to the single RF write port.
// Optional odd-rd pair trap enabled by defining AMA_RISCV_WB_PAIR_ODD_TRAP_EN.
module ama_riscv_wb_pair #(
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*XLEN-1:0] in_data,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_pair,
    input  logic              flush,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic {IDLE, HI} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   hi_data, hi_data_nxt;
    logic [ADDR_W-1:0] hi_addr, hi_addr_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [XLEN-1:0]   wdata_nxt;
    logic              accept;
    logic              odd_trap;

    assign in_ready = (state == IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == HI);

`ifdef AMA_RISCV_WB_PAIR_ODD_TRAP_EN
    assign odd_trap = accept && in_pair && in_rd[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= odd_trap;
    end
`else
    assign odd_trap = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        we_nxt      = 1'b0;
        addr_nxt    = rf_addr;
        wdata_nxt   = rf_wdata;
        hi_data_nxt = hi_data;
        hi_addr_nxt = hi_addr;
        case (state)
            IDLE: begin
                if (accept && !odd_trap) begin
                    addr_nxt  = in_rd;
                    wdata_nxt = in_data[XLEN-1:0];
                    // x0 is never written, but the port still shows the address/data
                    we_nxt    = (in_rd != '0);
                    if (in_pair) begin
                        hi_data_nxt = in_data[2*XLEN-1:XLEN];
                        hi_addr_nxt = in_rd + 1'b1;
                        state_nxt   = HI;
                    end
                end
            end
            HI: begin
                state_nxt = IDLE;
                if (!flush) begin
                    addr_nxt  = hi_addr;
                    wdata_nxt = hi_data;
                    we_nxt    = (hi_addr != '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            hi_data  <= '0;
            hi_addr  <= '0;
        end else begin
            state    <= state_nxt;
            rf_we    <= we_nxt;
            rf_addr  <= addr_nxt;
            rf_wdata <= wdata_nxt;
            hi_data  <= hi_data_nxt;
            hi_addr  <= hi_addr_nxt;
        end
    end

endmodule

// File: tb/tb_ama_riscv_wb_pair.sv
// Bench for ama_riscv_wb_pair: cycle vectors with expected outputs queued per driven cycle.
module tb_ama_riscv_wb_pair;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  in_rd;
    logic        in_pair;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    ama_riscv_wb_pair #(.ADDR_W(5), .XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_rd    (in_rd),
        .in_pair  (in_pair),
        .flush    (flush),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        busy;
        logic        err;
    } out_t;

    typedef struct {
        string       name;
        logic        vld;
        logic        pair;
        logic        fl;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        rdy;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input string name, input logic vld, input logic pair, input logic fl,
                                input logic [4:0] rd, input logic [63:0] data, input logic rdy,
                                input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                input logic bsy, input logic er);
        vec_t v;
        v.name = name; v.vld = vld; v.pair = pair; v.fl = fl; v.rd = rd; v.data = data; v.rdy = rdy;
        v.exp.we = we; v.exp.addr = addr; v.exp.wdata = wdata; v.exp.busy = bsy; v.exp.err = er;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t o;
        //                   name        vld pr fl rd  data                     rdy we addr wdata         busy err
        vecs.push_back(mk("single5",   1, 0, 0, 5,  64'hDEADBEEF_12345678, 1, 1, 5,  32'h12345678, 0, 0));
        vecs.push_back(mk("idle",      0, 0, 0, 0,  64'h0,                 1, 0, 5,  32'h12345678, 0, 0));
        vecs.push_back(mk("pair6_lo",  1, 1, 0, 6,  64'hAAAABBBB_CCCCDDDD, 1, 1, 6,  32'hCCCCDDDD, 1, 0));
        vecs.push_back(mk("pair6_hi",  0, 0, 0, 0,  64'h0,                 0, 1, 7,  32'hAAAABBBB, 0, 0));
        vecs.push_back(mk("b2b_lo8",   1, 1, 0, 8,  64'h11111111_22222222, 1, 1, 8,  32'h22222222, 1, 0));
        vecs.push_back(mk("b2b_hi9",   1, 0, 0, 3,  64'h0_33333333,        0, 1, 9,  32'h11111111, 0, 0));
        vecs.push_back(mk("b2b_s3",    1, 0, 0, 3,  64'h0_33333333,        1, 1, 3,  32'h33333333, 0, 0));
        vecs.push_back(mk("fl_lo10",   1, 1, 0, 10, 64'hA0A0A0A0_0A0A0A0A, 1, 1, 10, 32'h0A0A0A0A, 1, 0));
        vecs.push_back(mk("fl_hi",     0, 0, 1, 0,  64'h0,                 0, 0, 10, 32'h0A0A0A0A, 0, 0));
        vecs.push_back(mk("fl_idle",   1, 0, 1, 12, 64'h0_CCCCCCCC,        0, 0, 10, 32'h0A0A0A0A, 0, 0));
        vecs.push_back(mk("x0_lo",     1, 1, 0, 0,  64'h55555555_66666666, 1, 0, 0,  32'h66666666, 1, 0));
        vecs.push_back(mk("x0_hi1",    0, 0, 0, 0,  64'h0,                 0, 1, 1,  32'h55555555, 0, 0));
`ifdef AMA_RISCV_WB_PAIR_ODD_TRAP_EN
        vecs.push_back(mk("r31_trap",  1, 1, 0, 31, 64'h77777777_88888888, 1, 0, 1,  32'h55555555, 0, 1));
        vecs.push_back(mk("r31_after", 0, 0, 0, 0,  64'h0,                 1, 0, 1,  32'h55555555, 0, 0));
`else
        vecs.push_back(mk("r31_lo",    1, 1, 0, 31, 64'h77777777_88888888, 1, 1, 31, 32'h88888888, 1, 0));
        vecs.push_back(mk("r31_hi_x0", 0, 0, 0, 0,  64'h0,                 0, 0, 0,  32'h77777777, 0, 0));
`endif
        vecs.push_back(mk("single31",  1, 0, 0, 31, 64'h0_99999999,        1, 1, 31, 32'h99999999, 0, 0));
        vecs.push_back(mk("idle_end",  0, 0, 0, 0,  64'h0,                 1, 0, 31, 32'h99999999, 0, 0));

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rd = '0; in_pair = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].vld; in_pair = vecs[i].pair; flush = vecs[i].fl;
            in_rd = vecs[i].rd; in_data = vecs[i].data;
            #1;
            chk({vecs[i].name, "_ready"}, in_ready, vecs[i].rdy);
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            o = exp_q.pop_front();
            chk({vecs[i].name, "_we"}, rf_we, o.we);
            chk({vecs[i].name, "_addr"}, rf_addr, o.addr);
            chk({vecs[i].name, "_wdata"}, rf_wdata, o.wdata);
            chk({vecs[i].name, "_busy"}, busy, o.busy);
            chk({vecs[i].name, "_err"}, err, o.err);
            @(negedge clk);
        end

        // Reset asserted while the high word is pending
        in_valid = 1'b1; in_pair = 1'b1; flush = 1'b0; in_rd = 5'd20; in_data = 64'h21212121_20202020;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_pair = 1'b0;
        chk("rsthi_lo_we", rf_we, 1);
        chk("rsthi_lo_addr", rf_addr, 20);
        chk("rsthi_busy1", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rsthi_we0", rf_we, 0);
        chk("rsthi_busy0", busy, 0);
        chk("rsthi_addr0", rf_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rsthi_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("rsthi_nohi_we", rf_we, 0);
        chk("rsthi_nohi_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
